mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one SRAM-like memory port (req/addr_ok/data_ok handshake) between the
//  mips core's instruction-fetch and data-access channels. Sits between the core
//  and the unified memory/bridge in mycpu_top. Allows one outstanding transaction.
//  Round-robin arbitration on conflict.
// PARAMETERS
//  ADDR_W  32  address width, all address ports
//  DATA_W  32  data width, all data ports; byte-enable width is DATA_W/8
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst           in   1       synchronous reset, active-high
//  inst_req      in   1       fetch request; held with inst_addr until inst_addr_ok
//  inst_addr     in   ADDR_W  fetch physical address
//  inst_addr_ok  out  1       1-cycle pulse: fetch request accepted by memory
//  inst_data_ok  out  1       1-cycle pulse: inst_rdata valid
//  inst_rdata    out  DATA_W  fetched word
//  data_req      in   1       data request; held with all data_* until data_addr_ok
//  data_wr       in   1       1 = store, 0 = load
//  data_wen      in   DATA_W/8  byte enables for stores
//  data_addr     in   ADDR_W  data physical address
//  data_wdata    in   DATA_W  store data
//  data_addr_ok  out  1       1-cycle pulse: data request accepted
//  data_data_ok  out  1       1-cycle pulse: load data valid / store complete
//  data_rdata    out  DATA_W  load word
//  mem_req       out  1       request to memory
//  mem_wr        out  1       store flag to memory
//  mem_wen       out  DATA_W/8  byte enables to memory
//  mem_addr      out  ADDR_W  address to memory
//  mem_wdata     out  DATA_W  store data to memory
//  mem_addr_ok   in   1       memory accepts request (valid only while mem_req=1)
//  mem_data_ok   in   1       memory response; never in same cycle as its addr_ok
//  mem_rdata     in   DATA_W  memory read data
//  busy          out  1       1 in ISSUE or WAIT
// BEHAVIOUR
//  - States: IDLE, ISSUE, WAIT; registers owner (INST/DATA), last_grant.
//  - Reset: state=IDLE, owner=INST, last_grant=INST; all outputs 0 in the cycle
//    rst is sampled and the cycle after (mem_req=0, all *_ok=0, busy=0).
//  - IDLE grant (combinational): only one req -> that channel; both -> channel
//    not equal to last_grant (so data wins the first conflict after reset).
//    mem_req = inst_req|data_req; mem_* fields muxed from granted channel; for
//    inst: mem_wr=0, mem_wen=0, mem_wdata=0.
//  - IDLE, mem_req & mem_addr_ok: pulse granted *_addr_ok same cycle; owner<=grant,
//    last_grant<=grant; -> WAIT. mem_req & !mem_addr_ok: owner<=grant -> ISSUE.
//  - ISSUE: mem_req=1, fields from owner only (grant frozen; other channel's new
//    req ignored). On mem_addr_ok: pulse owner *_addr_ok, last_grant<=owner, -> WAIT.
//  - WAIT: mem_req=0. On mem_data_ok: owner *_data_ok=1 for that cycle, owner
//    *_rdata = mem_rdata (combinational pass-through) -> IDLE. New grant earliest
//    next cycle: minimum 2 cycles per transaction, no back-to-back issue.
//  - *_rdata of non-owner and outside data_ok cycles: 0.
//  - Store: data_data_ok pulses on mem_data_ok; data_rdata don't-care (driven 0).
//  - mem_data_ok or mem_addr_ok in a state not expecting it: ignored, no pulse.
//  - rst in ISSUE/WAIT: abandon transaction, -> IDLE, no *_ok pulses; a late
//    mem_data_ok after reset is ignored (IDLE).
//  - inst_addr_ok and data_addr_ok never high in same cycle; same for *_data_ok.
// TESTING
//  1 Reset: rst=1 two cycles, inst_req=data_req=1 -> mem_req=0, all *_ok=0, busy=0.
//  2 Fetch 0xBFC00000, addr_ok same cycle, data_ok 3 cycles later rdata 0x3C080001
//    -> inst_addr_ok cycle 0, inst_data_ok cycle 3 with 0x3C080001, data side silent.
//  3 Both req after reset: store 0x80000010/0xDEADBEEF wen 4'hF granted first,
//    fetch next; repeat both -> alternate DATA,INST,DATA,INST.
//  4 Fetch issued, mem_addr_ok held 0 for 4 cycles, data_req rises in cycle 1
//    -> mem_addr stays fetch address, mem_wr=0 throughout; data served after.
//  5 Load 0x80000020, mem_rdata 0x12345678 -> data_data_ok once, data_rdata
//    0x12345678, inst_rdata 0.
//  6 rst pulsed in WAIT, mem_data_ok 2 cycles later -> no *_data_ok, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the fetch and data channels.
// Single outstanding transaction; round-robin on simultaneous requests.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int WEN_W = DATA_W / 8;
  localparam logic CH_INST = 1'b0;
  localparam logic CH_DATA = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic              wr;
    logic [WEN_W-1:0]  wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t state, state_nxt;
  logic   owner, owner_nxt, last_grant, last_nxt, owner_wr, owner_wr_nxt;
  logic   quiet, block, grant, sel, accept, done;
  req_t   inst_r, data_r, sel_r;

  // Outputs stay silent while rst is sampled and for one cycle after.
  assign block  = rst | quiet;
  assign grant  = (inst_req & data_req) ? ~last_grant : data_req;
  assign sel    = (state == IDLE) ? grant : owner;
  assign inst_r = '{wr: 1'b0, wen: '0, addr: inst_addr, wdata: '0};
  assign data_r = '{wr: data_wr, wen: data_wen, addr: data_addr, wdata: data_wdata};
  assign sel_r  = (sel == CH_DATA) ? data_r : inst_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= CH_INST;
      last_grant <= CH_INST;
      owner_wr   <= 1'b0;
      quiet      <= 1'b1;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_nxt;
      owner_wr   <= owner_wr_nxt;
      quiet      <= 1'b0;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    last_nxt     = last_grant;
    owner_wr_nxt = owner_wr;
    case (state)
      IDLE: if (mem_req) begin
        owner_nxt    = grant;
        owner_wr_nxt = sel_r.wr;
        if (mem_addr_ok) begin
          last_nxt  = grant;
          state_nxt = WAIT;
        end else begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: if (accept) begin
        last_nxt  = owner;
        state_nxt = WAIT;
      end
      WAIT: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:    mem_req = (inst_req | data_req) & ~block;
      ISSUE:   mem_req = ~block;
      WAIT:    done    = mem_data_ok & ~block;
      default: mem_req = 1'b0;
    endcase
    accept       = mem_req & mem_addr_ok;
    inst_addr_ok = accept & (sel == CH_INST);
    data_addr_ok = accept & (sel == CH_DATA);
    inst_data_ok = done & (owner == CH_INST);
    data_data_ok = done & (owner == CH_DATA);
    inst_rdata   = inst_data_ok ? mem_rdata : '0;
    data_rdata   = (data_data_ok & ~owner_wr) ? mem_rdata : '0;
    mem_wr       = mem_req & sel_r.wr;
    mem_wen      = mem_req ? sel_r.wen : '0;
    mem_addr     = mem_req ? sel_r.addr : '0;
    mem_wdata    = mem_req ? sel_r.wdata : '0;
    busy         = (state != IDLE) & ~block;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: inline checks per task plus a
// response scoreboard fed when mem_data_ok is driven.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_req = 0, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr = 0, inst_rdata;
  logic        data_req = 0, data_wr = 0, data_addr_ok, data_data_ok;
  logic [3:0]  data_wen = 0, mem_wen;
  logic [31:0] data_addr = 0, data_wdata = 0, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok = 0, mem_data_ok = 0, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;

  typedef struct {bit is_data; bit chk; logic [31:0] rdata;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Every data_ok pulse must match the next expected response in order.
  always @(negedge clk) begin
    if (inst_data_ok || data_data_ok) begin
      exp_t e;
      logic [31:0] got, oth;
      n_cmp++;
      got = data_data_ok ? data_rdata : inst_rdata;
      oth = data_data_ok ? inst_rdata : data_rdata;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL sb_unexpected: inst_data_ok=%b data_data_ok=%b, none expected", inst_data_ok, data_data_ok);
      end else begin
        e = exp_q.pop_front();
        if (inst_data_ok && data_data_ok) begin
          n_err++; $display("FAIL sb_both_data_ok: both pulses high");
        end else if (data_data_ok !== e.is_data) begin
          n_err++; $display("FAIL sb_channel: got data=%b want data=%b", data_data_ok, e.is_data);
        end else if (e.chk && got !== e.rdata) begin
          n_err++; $display("FAIL sb_rdata: got %h want %h", got, e.rdata);
        end else if (oth !== 32'h0) begin
          n_err++; $display("FAIL sb_other_rdata: got %h want 0", oth);
        end
      end
    end
  end

  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic push(input bit is_data, input bit chk, input logic [31:0] rd);
    exp_t e;
    e.is_data = is_data; e.chk = chk; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    inst_req = 0; data_req = 0; data_wr = 0; data_wen = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs(); rst = 1; go(); rst = 0; go();
  endtask

  task automatic test_reset();
    rst = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rst = 0;
      @(negedge clk);
      n_cmp++;
      if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy} !== 6'b0) begin
        n_err++; $display("FAIL reset_quiet c%0d: req/aok/dok/busy=%b want 000000", c,
          {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy});
      end
      go();
    end
    clear_inputs();
  endtask

  task automatic test_fetch();
    inst_req = 1; inst_addr = 32'hBFC00000; mem_addr_ok = 1;
    @(negedge clk);
    n_cmp++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin n_err++; $display("FAIL fetch_addr_ok: inst=%b data=%b want 1/0", inst_addr_ok, data_addr_ok); end
    n_cmp++; if (mem_addr !== 32'hBFC00000 || mem_wr !== 1'b0) begin n_err++; $display("FAIL fetch_mem_addr: got %h wr=%b want bfc00000 wr=0", mem_addr, mem_wr); end
    go(); inst_req = 0; mem_addr_ok = 0;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if ({busy, mem_req, inst_data_ok, data_data_ok} !== 4'b1000) begin n_err++; $display("FAIL fetch_wait c%0d: busy/req/iok/dok=%b want 1000", c, {busy, mem_req, inst_data_ok, data_data_ok}); end
      go();
    end
    mem_data_ok = 1; mem_rdata = 32'h3C080001; push(0, 1, 32'h3C080001);
    @(negedge clk);
    n_cmp++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3C080001) begin n_err++; $display("FAIL fetch_data: ok=%b rdata=%h want 1 3c080001", inst_data_ok, inst_rdata); end
    go(); mem_data_ok = 0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fetch_idle: busy=%b want 0", busy); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL fetch_missing: %0d pending want 0", exp_q.size()); end
    go();
  endtask

  task automatic test_round_robin();
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00004;
    data_req = 1; data_wr = 1; data_wen = 4'hF; data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      bit exp_d;
      exp_d = (k % 2 == 0);
      mem_addr_ok = 1;
      @(negedge clk);
      n_cmp++; if (data_addr_ok !== exp_d || inst_addr_ok !== !exp_d) begin n_err++; $display("FAIL rr_grant k%0d: inst=%b data=%b want data=%b", k, inst_addr_ok, data_addr_ok, exp_d); end
      n_cmp++; if (mem_addr !== (exp_d ? 32'h80000010 : 32'hBFC00004) || mem_wr !== exp_d) begin n_err++; $display("FAIL rr_mem k%0d: addr=%h wr=%b", k, mem_addr, mem_wr); end
      if (exp_d) begin
        n_cmp++; if (mem_wdata !== 32'hDEADBEEF || mem_wen !== 4'hF) begin n_err++; $display("FAIL rr_store k%0d: wdata=%h wen=%h want deadbeef f", k, mem_wdata, mem_wen); end
      end
      go();
      mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1000 + k; push(exp_d, !exp_d, 32'h1000 + k);
      @(negedge clk);
      n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rr_no_b2b k%0d: mem_req=%b want 0", k, mem_req); end
      go(); mem_data_ok = 0;
    end
    clear_inputs();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_missing: %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    bit found = 0;
    inst_req = 1; inst_addr = 32'hBFC00100;
    for (int c = 0; c < 5; c++) begin
      if (c >= 1) begin
        data_req = 1; data_wr = 1; data_wen = 4'h3; data_addr = 32'h80000030; data_wdata = 32'h0000ABCD;
      end
      mem_addr_ok = (c == 4);
      @(negedge clk);
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC00100 || mem_wr !== 1'b0) begin n_err++; $display("FAIL stall_hold c%0d: req=%b addr=%h wr=%b want 1 bfc00100 0", c, mem_req, mem_addr, mem_wr); end
      n_cmp++; if (inst_addr_ok !== (c == 4) || data_addr_ok !== 1'b0) begin n_err++; $display("FAIL stall_aok c%0d: inst=%b data=%b", c, inst_addr_ok, data_addr_ok); end
      go();
    end
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h24020005; push(0, 1, 32'h24020005);
    @(negedge clk); go(); mem_data_ok = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      mem_addr_ok = 1;
      @(negedge clk);
      if (data_addr_ok) begin
        found = 1;
        n_cmp++; if (mem_addr !== 32'h80000030 || mem_wr !== 1'b1 || mem_wen !== 4'h3 || mem_wdata !== 32'h0000ABCD) begin n_err++; $display("FAIL stall_data_mem: addr=%h wr=%b wen=%h wdata=%h", mem_addr, mem_wr, mem_wen, mem_wdata); end
      end
      go();
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL stall_data_timeout: data_addr_ok=0 want 1 within 5 cycles"); end
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0; push(1, 0, 32'h0);
    @(negedge clk); go(); clear_inputs();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_missing: %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_load();
    int pulses = 0;
    data_req = 1; data_wr = 0; data_wen = 4'h0; data_addr = 32'h80000020; mem_addr_ok = 1;
    @(negedge clk);
    n_cmp++; if (data_addr_ok !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h80000020) begin n_err++; $display("FAIL load_issue: aok=%b wr=%b addr=%h", data_addr_ok, mem_wr, mem_addr); end
    go(); data_req = 0; mem_addr_ok = 0;
    @(negedge clk);
    n_cmp++; if (data_data_ok !== 1'b0) begin n_err++; $display("FAIL load_early: data_data_ok=%b want 0", data_data_ok); end
    go(); mem_data_ok = 1; mem_rdata = 32'h12345678; push(1, 1, 32'h12345678);
    @(negedge clk);
    n_cmp++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h12345678 || inst_rdata !== 32'h0) begin n_err++; $display("FAIL load_data: ok=%b rdata=%h inst_rdata=%h want 1 12345678 0", data_data_ok, data_rdata, inst_rdata); end
    go();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); pulses += int'(data_data_ok); go(); mem_data_ok = 0;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL load_once: %0d extra pulses want 0", pulses); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL load_missing: %0d pending want 0", exp_q.size()); end
    clear_inputs();
  endtask

  task automatic test_reset_in_wait();
    inst_req = 1; inst_addr = 32'hBFC00200; mem_addr_ok = 1;
    @(negedge clk);
    n_cmp++; if (inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL rw_issue: inst_addr_ok=%b want 1", inst_addr_ok); end
    go(); inst_req = 0; mem_addr_ok = 0; rst = 1;
    @(negedge clk);
    n_cmp++; if ({busy, mem_req, inst_data_ok, data_data_ok} !== 4'b0) begin n_err++; $display("FAIL rw_rst: busy/req/iok/dok=%b want 0000", {busy, mem_req, inst_data_ok, data_data_ok}); end
    go(); rst = 0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rw_after: busy=%b want 0", busy); end
    go(); mem_data_ok = 1; mem_rdata = 32'hDEAD0000;
    @(negedge clk);
    n_cmp++; if ({inst_data_ok, data_data_ok, busy} !== 3'b0) begin n_err++; $display("FAIL rw_late: iok/dok/busy=%b want 000", {inst_data_ok, data_data_ok, busy}); end
    go(); clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_round_robin();
    test_stall();
    test_load();
    test_reset_in_wait();
    repeat (2) go();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
